n64adv2_clk_monitor: RTL and testbench



---
 rtl/n64adv2_clk_monitor.sv | 175 +++++++++++++++++
 tb/tb_n64adv2_clk_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/n64adv2_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : n64adv2_clk_monitor
// Brief    : Counts edges of a toggle from a monitored clock domain over a gate
//            window and qualifies that clock as present/in-range with hysteresis.
// Revision : 1.0 - initial release
// ============================================================================
module n64adv2_clk_monitor #(
    parameter int GATE_LEN     = 1000,
    parameter int CNT_W        = 16,
    parameter int MIN_CNT      = 400,
    parameter int MAX_CNT      = 600,
    parameter int OK_CONFIRM   = 3,
    parameter int LOSS_CONFIRM = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clk_en,
    input  logic             mon_tgl_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_valid_o,
    output logic             clk_ok_o,
    output logic             clk_lost_o
);

    localparam int GATE_W = $clog2(GATE_LEN);
    localparam int GOOD_W = (OK_CONFIRM > 1) ? $clog2(OK_CONFIRM) : 1;
    localparam int BAD_W  = (LOSS_CONFIRM > 1) ? $clog2(LOSS_CONFIRM) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(OK_CONFIRM - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_CONFIRM - 1);
    localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CNT);

    localparam logic [1:0] ST_LOST    = 2'd0;
    localparam logic [1:0] ST_CHECK   = 2'd1;
    localparam logic [1:0] ST_OK      = 2'd2;
    localparam logic [1:0] ST_SUSPECT = 2'd3;

    logic              sync1, sync2, hist;
    logic              tgl_edge;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  new_cnt;
    logic              win_end;
    logic              in_range;
    logic [1:0]        state, state_nx;
    logic [GOOD_W-1:0] good, good_nx;
    logic [BAD_W-1:0]  bad, bad_nx;
    logic              ok_d, lost_d;

    // Free-running synchronizer: it must track the toggle even while clk_en is low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= mon_tgl_i;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign tgl_edge = sync2 ^ hist;
    assign win_end  = clk_en && (gate_cnt == '0);
    assign cnt_sum  = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, tgl_edge};
    assign new_cnt  = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    assign in_range = (new_cnt >= CNT_MIN) && (new_cnt <= CNT_MAX);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gate_cnt <= GATE_LAST;
            edge_cnt <= '0;
        end else if (clk_en) begin
            gate_cnt <= win_end ? GATE_LAST : gate_cnt - GATE_W'(1);
            edge_cnt <= win_end ? '0 : new_cnt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_LOST;
            good  <= '0;
            bad   <= '0;
        end else begin
            state <= state_nx;
            good  <= good_nx;
            bad   <= bad_nx;
        end
    end

    always_comb begin
        state_nx = state;
        good_nx  = good;
        bad_nx   = bad;
        if (win_end) begin
            case (state)
                ST_LOST: begin
                    if (in_range) begin
                        if (OK_CONFIRM == 1) begin
                            state_nx = ST_OK;
                        end else begin
                            state_nx = ST_CHECK;
                            good_nx  = GOOD_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (!in_range) begin
                        state_nx = ST_LOST;
                        good_nx  = '0;
                    end else if (good == GOOD_LAST) begin
                        state_nx = ST_OK;
                        good_nx  = '0;
                    end else begin
                        good_nx  = good + GOOD_W'(1);
                    end
                end
                ST_OK: begin
                    if (!in_range) begin
                        if (LOSS_CONFIRM == 1) begin
                            state_nx = ST_LOST;
                        end else begin
                            state_nx = ST_SUSPECT;
                            bad_nx   = BAD_W'(1);
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (in_range) begin
                        state_nx = ST_OK;
                        bad_nx   = '0;
                    end else if (bad == BAD_LAST) begin
                        state_nx = ST_LOST;
                        bad_nx   = '0;
                    end else begin
                        bad_nx   = bad + BAD_W'(1);
                    end
                end
                default: begin
                    state_nx = ST_LOST;
                    good_nx  = '0;
                    bad_nx   = '0;
                end
            endcase
        end
    end

    // A loss pulse is only meaningful when leaving a qualified state.
    always_comb begin
        ok_d   = (state == ST_OK) || (state == ST_SUSPECT);
        lost_d = win_end && ok_d && (state_nx == ST_LOST);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_o       <= '0;
            cnt_valid_o <= 1'b0;
            clk_ok_o    <= 1'b0;
            clk_lost_o  <= 1'b0;
        end else begin
            if (win_end) begin
                cnt_o <= new_cnt;
            end
            cnt_valid_o <= win_end;
            clk_ok_o    <= ok_d;
            clk_lost_o  <= lost_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_n64adv2_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_n64adv2_clk_monitor
// Brief    : Scoreboard bench for two clock-monitor configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n64adv2_clk_monitor;

    typedef struct {
        int   at;
        int   lo;
        int   hi;
        logic lost;
        logic ok_at;
        logic ok_after;
    } exp_t;

    logic        clk;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    exp_t        qa[$];
    exp_t        qb[$];

    logic        nrst_a, clk_en_a, tgl_a;
    logic [15:0] cnt_a;
    logic        cnt_valid_a, clk_ok_a, clk_lost_a;
    int          per_a;

    logic        nrst_b, clk_en_b, tgl_b;
    logic [3:0]  cnt_b;
    logic        cnt_valid_b, clk_ok_b, clk_lost_b;
    int          per_b;

    n64adv2_clk_monitor #(
        .GATE_LEN(100), .CNT_W(16), .MIN_CNT(20), .MAX_CNT(30),
        .OK_CONFIRM(3), .LOSS_CONFIRM(2)
    ) dut_a (
        .clk(clk), .nrst(nrst_a), .clk_en(clk_en_a), .mon_tgl_i(tgl_a),
        .cnt_o(cnt_a), .cnt_valid_o(cnt_valid_a), .clk_ok_o(clk_ok_a), .clk_lost_o(clk_lost_a)
    );

    n64adv2_clk_monitor #(
        .GATE_LEN(100), .CNT_W(4), .MIN_CNT(10), .MAX_CNT(14),
        .OK_CONFIRM(1), .LOSS_CONFIRM(1)
    ) dut_b (
        .clk(clk), .nrst(nrst_b), .clk_en(clk_en_b), .mon_tgl_i(tgl_b),
        .cnt_o(cnt_b), .cnt_valid_o(cnt_valid_b), .clk_ok_o(clk_ok_b), .clk_lost_o(clk_lost_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic push(input bit sel_b, input int at, input int lo, input int hi,
                        input logic lost, input logic ok_at, input logic ok_after);
        exp_t e;
        e.at = at; e.lo = lo; e.hi = hi;
        e.lost = lost; e.ok_at = ok_at; e.ok_after = ok_after;
        if (sel_b) qb.push_back(e);
        else       qa.push_back(e);
    endtask

    task automatic check_entry(input string p, input int w, input exp_t e,
                               input int cnt, input logic lost, input logic ok);
        chk($sformatf("%s.w%0d.cycle", p, w), cyc, e.at);
        chk_rng($sformatf("%s.w%0d.cnt", p, w), cnt, e.lo, e.hi);
        chk($sformatf("%s.w%0d.lost", p, w), lost, e.lost);
        chk($sformatf("%s.w%0d.ok_at_valid", p, w), ok, e.ok_at);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Toggle sources: one transition every per_x system clocks, frozen when per_x is 0.
    initial begin : gen_a
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (per_a == 0) ph = 0;
            else if (ph >= per_a - 1) begin tgl_a = ~tgl_a; ph = 0; end
            else ph++;
        end
    end

    initial begin : gen_b
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (per_b == 0) ph = 0;
            else if (ph >= per_b - 1) begin tgl_b = ~tgl_b; ph = 0; end
            else ph++;
        end
    end

    initial begin : mon_a
        exp_t e;
        logic pend, pend_ok;
        int   w;
        pend = 1'b0; pend_ok = 1'b0; w = 0;
        forever begin
            @(posedge clk); #1;
            if (pend) begin
                chk($sformatf("A.w%0d.ok_after", w), clk_ok_a, pend_ok);
                pend = 1'b0;
            end
            chk("A.stray_lost", clk_lost_a & ~cnt_valid_a, 0);
            if (cnt_valid_a) begin
                w++;
                chk($sformatf("A.w%0d.valid_expected", w), qa.size() != 0, 1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    check_entry("A", w, e, cnt_a, clk_lost_a, clk_ok_a);
                    pend = 1'b1; pend_ok = e.ok_after;
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        logic pend, pend_ok;
        int   w;
        pend = 1'b0; pend_ok = 1'b0; w = 0;
        forever begin
            @(posedge clk); #1;
            if (pend) begin
                chk($sformatf("B.w%0d.ok_after", w), clk_ok_b, pend_ok);
                pend = 1'b0;
            end
            chk("B.stray_lost", clk_lost_b & ~cnt_valid_b, 0);
            if (cnt_valid_b) begin
                w++;
                chk($sformatf("B.w%0d.valid_expected", w), qb.size() != 0, 1);
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    check_entry("B", w, e, cnt_b, clk_lost_b, clk_ok_b);
                    pend = 1'b1; pend_ok = e.ok_after;
                end
            end
        end
    end

    initial begin : stim
        int base, base2, bb;
        n_cmp = 0; n_bad = 0;
        nrst_a = 1'b0; clk_en_a = 1'b1; tgl_a = 1'b0; per_a = 4;
        nrst_b = 1'b0; clk_en_b = 1'b1; tgl_b = 1'b0; per_b = 0;

        // Reset held with the toggle running: everything stays at zero.
        repeat (20) @(negedge clk);
        chk("A.rst.cnt", cnt_a, 0);
        chk("A.rst.valid", cnt_valid_a, 0);
        chk("A.rst.ok", clk_ok_a, 0);
        chk("A.rst.lost", clk_lost_a, 0);

        // Acquire: three good windows, ok one cycle after the third valid.
        nrst_a = 1'b1;
        base = cyc;
        push(0, base + 100, 22, 27, 0, 0, 0);
        push(0, base + 200, 24, 26, 0, 0, 0);
        push(0, base + 300, 24, 26, 0, 0, 1);
        push(0, base + 400, 24, 26, 0, 1, 1);

        // One fast window while ok is absorbed by the suspect state.
        wait_cyc(base + 400); per_a = 2;
        push(0, base + 500, 45, 52, 0, 1, 1);
        wait_cyc(base + 500); per_a = 4;
        push(0, base + 600, 23, 28, 0, 1, 1);
        push(0, base + 700, 24, 26, 0, 1, 1);

        // Loss: second empty window drops ok with a single lost pulse.
        wait_cyc(base + 700); per_a = 0;
        push(0, base + 800, 0, 2, 0, 1, 1);
        push(0, base + 900, 0, 0, 1, 1, 0);
        push(0, base + 1000, 0, 0, 0, 0, 0);

        // Re-acquire, but a bad window during checking restarts the count.
        wait_cyc(base + 1000); per_a = 4;
        push(0, base + 1100, 22, 26, 0, 0, 0);
        push(0, base + 1200, 24, 26, 0, 0, 0);
        wait_cyc(base + 1200); per_a = 2;
        push(0, base + 1300, 45, 52, 0, 0, 0);
        wait_cyc(base + 1300); per_a = 4;
        push(0, base + 1400, 23, 28, 0, 0, 0);
        push(0, base + 1500, 24, 26, 0, 0, 0);
        push(0, base + 1600, 24, 26, 0, 0, 1);

        // One-cycle reset at mid-window clears outputs asynchronously.
        wait_cyc(base + 1650);
        nrst_a = 1'b0;
        #1;
        chk("A.midrst.ok", clk_ok_a, 0);
        chk("A.midrst.cnt", cnt_a, 0);
        chk("A.midrst.valid", cnt_valid_a, 0);
        @(negedge clk);
        nrst_a = 1'b1;
        base2 = cyc;
        push(0, base2 + 100, 22, 27, 0, 0, 0);
        push(0, base2 + 200, 24, 26, 0, 0, 0);
        push(0, base2 + 300, 24, 26, 0, 0, 1);
        wait_cyc(base2 + 305);
        nrst_a = 1'b0;

        // Narrow counter, single-window confirm/loss, clk_en stalls.
        nrst_b = 1'b1;
        per_b = 8;
        bb = cyc;
        push(1, bb + 100, 10, 13, 0, 0, 1);
        wait_cyc(bb + 100); per_b = 2;
        push(1, bb + 200, 15, 15, 1, 1, 0);
        push(1, bb + 350, 15, 15, 0, 0, 0);
        wait_cyc(bb + 250); clk_en_b = 1'b0;
        wait_cyc(bb + 300); clk_en_b = 1'b1;
        wait_cyc(bb + 340); per_b = 8;
        push(1, bb + 450, 11, 14, 0, 0, 1);
        push(1, bb + 600, 11, 14, 0, 1, 1);
        wait_cyc(bb + 500); clk_en_b = 1'b0;
        wait_cyc(bb + 550); clk_en_b = 1'b1;
        wait_cyc(bb + 605);
        nrst_b = 1'b0;

        chk("A.queue_drained", qa.size(), 0);
        chk("B.queue_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
